// File: rtl/data_memory_bank.sv
// data_memory_bank
//   Multi-cycle data memory for the RV32I memory stage. Each access takes a
//   fixed IDLE -> FETCH -> READ|WRITE -> IDLE walk. clk_stall holds the core
//   for exactly two cycles per access. Supported operations:
//     - byte, halfword and word loads/stores, with optional sign extension
//     - a read-back LED register at LED_ADDR
//     - out-of-range fault detection
//
//   Optional feature: define DATA_MEM_MISALIGN_TRAP_EN to fault misaligned
//   halfword and word accesses. Without it, the offending low address bits
//   are ignored.
//
//   Ports
//     clk         clock, posedge
//     rst_n       asynchronous active-low reset
//     addr        byte address of the access
//     write_data  store data, LSB-aligned
//     memwrite    store request
//     memread     load request (wins when both request lines are set)
//     sign_mask   [2]=word, [1]=halfword, neither=byte, [3]=sign-extend loads
//     read_data   registered load result
//     clk_stall   high while an access is in flight
//     led         LED register bits [LED_W-1:0]
//     access_err  one-cycle pulse when a faulted access completes
module data_memory_bank #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter logic [31:0] LED_ADDR    = 32'h0000_2000,
    parameter int          LED_W       = 8,
    parameter              INIT_FILE   = "verilog/data.hex"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr,
    input  logic [31:0]      write_data,
    input  logic             memwrite,
    input  logic             memread,
    input  logic [3:0]       sign_mask,
    output logic [31:0]      read_data,
    output logic             clk_stall,
    output logic [LED_W-1:0] led,
    output logic             access_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int IW = (AW > 0) ? AW : 1;

    // First byte address past the array. This is 33 bits wide so that an
    // array ending at 4 GiB cannot wrap the comparison.
    localparam logic [32:0] TOP_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {IDLE, FETCH, READ, WRITE} state_t;

    state_t      state;
    logic [31:0] addr_buf;
    logic [31:0] wdata_buf;
    logic [3:0]  sign_mask_buf;
    logic        memread_buf;
    logic        memwrite_buf;
    logic        fault_q;
    logic        led_hit_q;
    logic [31:0] led_reg;
    logic [31:0] word_buf;

    logic [31:0] mem [DEPTH_WORDS];

    // Address decode of the captured request
    logic [31:0]   offset;
    logic [IW-1:0] idx;
    logic          led_hit_c;
    logic          in_range_c;
    logic          misalign_c;
    logic          fault_c;

    // Index relative to BASE_ADDR. For a base aligned to the array size this
    // equals addr[AW+1:2]. Out-of-range addresses are blocked by fault_c, so
    // they never alias onto low words.
    assign offset     = addr_buf - BASE_ADDR;
    assign idx        = IW'(offset >> 2);
    assign led_hit_c  = (addr_buf == LED_ADDR);
    assign in_range_c = (addr_buf >= BASE_ADDR) && ({1'b0, addr_buf} < TOP_ADDR);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    assign misalign_c = sign_mask_buf[2] ? (addr_buf[1:0] != 2'b00)
                      : (sign_mask_buf[1] & addr_buf[0]);
`else
    assign misalign_c = 1'b0;
`endif

    assign fault_c = (!led_hit_c && !in_range_c) || misalign_c;

    // Load extraction from the fetched word
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_c;

    always_comb begin
        byte_v = word_buf[{addr_buf[1:0], 3'b000} +: 8];
        half_v = word_buf[{addr_buf[1], 4'b0000} +: 16];
        if (sign_mask_buf[2])
            load_c = word_buf;
        else if (sign_mask_buf[1])
            load_c = {{16{sign_mask_buf[3] & half_v[15]}}, half_v};
        else
            load_c = {{24{sign_mask_buf[3] & byte_v[7]}}, byte_v};
    end

    // Store merge into the fetched word. LED stores use the same merge.
    logic [31:0] merged_c;

    always_comb begin
        merged_c = word_buf;
        if (sign_mask_buf[2])
            merged_c = wdata_buf;
        else if (sign_mask_buf[1])
            merged_c[{addr_buf[1], 4'b0000} +: 16] = wdata_buf[15:0];
        else
            merged_c[{addr_buf[1:0], 3'b000} +: 8] = wdata_buf[7:0];
    end

    // The write enable is derived from the async-reset state, so asserting
    // reset mid-access immediately suppresses the array write.
    logic mem_we;
    assign mem_we = (state == WRITE) && !fault_q && !led_hit_q;

    // Array port (no reset: contents survive reset)
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx] <= merged_c;
        if (state == FETCH)
            word_buf <= led_hit_c ? led_reg : mem[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_buf      <= '0;
            wdata_buf     <= '0;
            sign_mask_buf <= '0;
            memread_buf   <= 1'b0;
            memwrite_buf  <= 1'b0;
            fault_q       <= 1'b0;
            led_hit_q     <= 1'b0;
            led_reg       <= '0;
            read_data     <= '0;
            clk_stall     <= 1'b0;
            access_err    <= 1'b0;
        end else begin
            access_err <= 1'b0;
            case (state)
                IDLE: begin
                    addr_buf      <= addr;
                    wdata_buf     <= write_data;
                    sign_mask_buf <= sign_mask;
                    memread_buf   <= memread;
                    memwrite_buf  <= memwrite;
                    if (memread | memwrite) begin
                        state     <= FETCH;
                        clk_stall <= 1'b1;
                    end
                end
                FETCH: begin
                    fault_q   <= fault_c;
                    led_hit_q <= led_hit_c;
                    // A combined read+write request is serviced as a read;
                    // the store is dropped silently.
                    state     <= memread_buf ? READ : WRITE;
                end
                READ: begin
                    read_data  <= fault_q ? 32'h0 : load_c;
                    access_err <= fault_q;
                    clk_stall  <= 1'b0;
                    state      <= IDLE;
                end
                WRITE: begin
                    if (!fault_q && led_hit_q && memwrite_buf)
                        led_reg <= merged_c;
                    access_err <= fault_q;
                    clk_stall  <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign led = led_reg[LED_W-1:0];

endmodule

// File: tb/tb_data_memory_bank.sv
module tb_data_memory_bank;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] LEDA  = 32'h0000_2000;
    localparam logic [31:0] TOPA  = BASE + 32'(DEPTH * 4);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memwrite;
    logic        memread;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic        clk_stall;
    logic [7:0]  led;
    logic        access_err;

    data_memory_bank #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .LED_ADDR   (LEDA),
        .LED_W      (8),
        .INIT_FILE  ("")
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .write_data(write_data),
        .memwrite  (memwrite),
        .memread   (memread),
        .sign_mask (sign_mask),
        .read_data (read_data),
        .clk_stall (clk_stall),
        .led       (led),
        .access_err(access_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  sm;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [7:0]  exp_led;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access: drive before E0, drop request after E0, count stall cycles
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] sm,
                             output int stall_n, output logic [31:0] rdat,
                             output logic err_e2, output logic err_e3);
        @(negedge clk);
        memread = rd; memwrite = wr; addr = a; write_data = wd; sign_mask = sm;
        @(posedge clk); #1;
        memread = 1'b0; memwrite = 1'b0;
        stall_n = 0;
        while (clk_stall && stall_n < 8) begin
            stall_n++;
            @(posedge clk); #1;
        end
        rdat   = read_data;
        err_e2 = access_err;
        @(posedge clk); #1;
        err_e3 = access_err;
    endtask

    initial begin
        int          sn;
        logic [31:0] rdat;
        logic        e2, e3;

        // rd wr addr wdata sm exp_rd err led
        vecs[0]  = '{0, 1, BASE + 8,    32'hDEADBEEF, 4'b0100, 32'h0,        0, 8'h00};
        vecs[1]  = '{1, 0, BASE + 8,    32'h0,        4'b0100, 32'hDEADBEEF, 0, 8'h00};
        vecs[2]  = '{0, 1, BASE + 9,    32'h12345680, 4'b0000, 32'h0,        0, 8'h00};
        vecs[3]  = '{1, 0, BASE + 9,    32'h0,        4'b1000, 32'hFFFFFF80, 0, 8'h00};
        vecs[4]  = '{1, 0, BASE + 9,    32'h0,        4'b0000, 32'h00000080, 0, 8'h00};
        vecs[5]  = '{1, 0, BASE + 8,    32'h0,        4'b0100, 32'hDEAD80EF, 0, 8'h00};
        vecs[6]  = '{0, 1, BASE + 10,   32'hABCD8001, 4'b0010, 32'h0,        0, 8'h00};
        vecs[7]  = '{1, 0, BASE + 10,   32'h0,        4'b1010, 32'hFFFF8001, 0, 8'h00};
        vecs[8]  = '{1, 0, BASE + 10,   32'h0,        4'b0010, 32'h00008001, 0, 8'h00};
        vecs[9]  = '{1, 0, BASE + 8,    32'h0,        4'b0100, 32'h800180EF, 0, 8'h00};
        vecs[10] = '{1, 0, BASE + 11,   32'h0,        4'b1000, 32'hFFFFFF80, 0, 8'h00};
        vecs[11] = '{1, 0, BASE + 8,    32'h0,        4'b0000, 32'h000000EF, 0, 8'h00};
        vecs[12] = '{0, 1, LEDA,        32'h0000005A, 4'b0100, 32'h0,        0, 8'h5A};
        vecs[13] = '{1, 0, LEDA,        32'h0,        4'b0100, 32'h0000005A, 0, 8'h5A};
        vecs[14] = '{0, 1, LEDA,        32'h123456A5, 4'b0100, 32'h0,        0, 8'hA5};
        vecs[15] = '{0, 1, LEDA,        32'h0000003C, 4'b0000, 32'h0,        0, 8'h3C};
        vecs[16] = '{1, 0, LEDA,        32'h0,        4'b0100, 32'h1234563C, 0, 8'h3C};
        vecs[17] = '{0, 1, BASE,        32'h11111111, 4'b0100, 32'h0,        0, 8'h3C};
        vecs[18] = '{1, 0, TOPA,        32'h0,        4'b0100, 32'h00000000, 1, 8'h3C};
        vecs[19] = '{0, 1, TOPA,        32'hCAFEF00D, 4'b0100, 32'h0,        1, 8'h3C};
        vecs[20] = '{1, 0, BASE,        32'h0,        4'b0100, 32'h11111111, 0, 8'h3C};
        vecs[21] = '{1, 0, BASE - 4,    32'h0,        4'b0100, 32'h00000000, 1, 8'h3C};
        vecs[22] = '{0, 1, TOPA - 1,    32'h00000077, 4'b0000, 32'h0,        0, 8'h3C};
        vecs[23] = '{1, 0, TOPA - 1,    32'h0,        4'b0000, 32'h00000077, 0, 8'h3C};
        vecs[24] = '{1, 1, BASE,        32'h0,        4'b0100, 32'h11111111, 0, 8'h3C};
        vecs[25] = '{1, 0, BASE,        32'h0,        4'b0100, 32'h11111111, 0, 8'h3C};
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        vecs[26] = '{1, 0, BASE + 2,    32'h0,        4'b0100, 32'h00000000, 1, 8'h3C};
        vecs[27] = '{1, 0, BASE + 3,    32'h0,        4'b1010, 32'h00000000, 1, 8'h3C};
`else
        vecs[26] = '{1, 0, BASE + 2,    32'h0,        4'b0100, 32'h11111111, 0, 8'h3C};
        vecs[27] = '{1, 0, BASE + 3,    32'h0,        4'b1010, 32'h00001111, 0, 8'h3C};
`endif

        rst_n = 1'b0; addr = '0; write_data = '0; memread = 1'b0; memwrite = 1'b0; sign_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_stall", {31'b0, clk_stall}, 32'h0);
        chk("reset_err", {31'b0, access_err}, 32'h0);
        chk("reset_led", {24'b0, led}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].sm, sn, rdat, e2, e3);
            chk($sformatf("v%0d_stall_cycles", i), 32'(sn), 32'd2);
            chk($sformatf("v%0d_err", i), {31'b0, e2}, {31'b0, vecs[i].exp_err});
            chk($sformatf("v%0d_err_pulse_end", i), {31'b0, e3}, 32'h0);
            if (vecs[i].rd)
                chk($sformatf("v%0d_read_data", i), rdat, vecs[i].exp_rd);
            chk($sformatf("v%0d_led", i), {24'b0, led}, {24'b0, vecs[i].exp_led});
        end

        // Reset during FETCH of a store: nothing written, stall drops at once
        @(negedge clk);
        memwrite = 1'b1; addr = BASE; write_data = 32'hBAD0BAD0; sign_mask = 4'b0100;
        @(posedge clk); #1;
        memwrite = 1'b0;
        chk("abort_stall_in_fetch", {31'b0, clk_stall}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_stall_drop", {31'b0, clk_stall}, 32'h0);
        chk("abort_led_cleared", {24'b0, led}, 32'h0);
        chk("abort_read_data", read_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_stall_idle", {31'b0, clk_stall}, 32'h0);
        do_access(1'b1, 1'b0, BASE, 32'h0, 4'b0100, sn, rdat, e2, e3);
        chk("post_abort_stall_cycles", 32'(sn), 32'd2);
        chk("post_abort_word_unchanged", rdat, 32'h11111111);
        chk("post_abort_err", {31'b0, e2}, 32'h0);

        // Reset during FETCH of an LED store: the register stays cleared
        @(negedge clk);
        memwrite = 1'b1; addr = LEDA; write_data = 32'h00000099; sign_mask = 4'b0100;
        @(posedge clk); #1;
        memwrite = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_access(1'b1, 1'b0, LEDA, 32'h0, 4'b0100, sn, rdat, e2, e3);
        chk("led_abort_readback", rdat, 32'h0);
        chk("led_abort_led", {24'b0, led}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
